edge_detect_multi: RTL and testbench
====================================

EDGE_DETECT_MULTI -- requirements
Module: edge_detect_multi

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent input channels, range 1..32.
REQ-002 Parameter SYNC_STAGES, default 2: synchroniser flop depth per channel, range 2..4.
REQ-003 Parameter DEBOUNCE_CYCLES, default 16: consecutive cycles a changed input must stay stable before it is accepted, range 1..65535.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 data_in  input  CHANNELS  raw asynchronous inputs, bit i = channel i.
REQ-007 mode  input  2*CHANNELS  per-channel detect mode, bits [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both.
REQ-008 clear  input  CHANNELS  write-1-to-clear strobe for pending bits.
REQ-009 level  output  CHANNELS  debounced, synchronised level per channel.
REQ-010 pulse  output  CHANNELS  one-cycle registered strobe per qualifying edge.
REQ-011 pending  output  CHANNELS  sticky event flags.
REQ-012 irq  output  1  OR of all pending bits.

Function
REQ-013 Each channel SHALL pass data_in[i] through SYNC_STAGES flops; the last stage output is the synchronised sample s[i].
REQ-014 Each channel SHALL hold a debounce counter of width clog2(DEBOUNCE_CYCLES)+1 and a debounced level d[i], output as level[i].
REQ-015 When s[i] == d[i], the counter SHALL reset to 0 on the next edge.
REQ-016 When s[i] != d[i] and counter < DEBOUNCE_CYCLES-1, the counter SHALL increment by 1.
REQ-017 When s[i] != d[i] and counter == DEBOUNCE_CYCLES-1, d[i] SHALL take s[i], the counter SHALL return to 0, and an edge SHALL be accepted that cycle.
REQ-018 A deviation of s[i] lasting fewer than DEBOUNCE_CYCLES cycles SHALL NOT change d[i] or produce any pulse; the counter SHALL never wrap.
REQ-019 An accepted 0->1 edge qualifies when mode[2i]=1; an accepted 1->0 edge qualifies when mode[2i+1]=1; mode SHALL be sampled on the accept cycle.
REQ-020 A qualifying edge SHALL assert pulse[i] for exactly one cycle, in the cycle immediately after the accept edge.
REQ-021 Latency: an input change held stable SHALL produce pulse[i] high starting exactly SYNC_STAGES+DEBOUNCE_CYCLES rising edges after the first edge sampling the new value.
REQ-022 Mode 00 SHALL suppress pulse and pending but level SHALL keep tracking.
REQ-023 A qualifying edge SHALL set pending[i] on the same edge that asserts pulse[i].
REQ-024 clear[i]=1 SHALL clear pending[i] on the next edge; if set and clear coincide, pending[i] SHALL be 1 (set wins).
REQ-025 irq SHALL be the combinational OR of the pending registers; no additional latency.
REQ-026 Channels SHALL be fully independent; simultaneous edges on several channels SHALL each pulse in the same cycle.

Reset
REQ-027 While rst=1, all synchroniser flops, counters, level, pulse and pending SHALL be 0 on the next edge; irq SHALL be 0 thereafter.
REQ-028 rst asserted mid-debounce SHALL discard the partial count; no pulse SHALL be issued for the interrupted edge.
REQ-029 After rst deasserts with data_in[i] held high, the channel SHALL detect a rising edge after the REQ-021 latency (reset level is 0).
REQ-030 clear and mode values during rst SHALL have no effect.

Verification
REQ-031 Defaults, mode=01 on ch0, data_in[0] 0->1 held -> pulse[0] high for 1 cycle at edge 18, pending[0]=1, irq=1, level[0]=1.
REQ-032 DEBOUNCE_CYCLES=16, data_in[1] high for 15 cycles then low, mode=11 -> no pulse, level[1] stays 0, pending[1] stays 0.
REQ-033 mode=10 on ch2, 0->1 then 1->0 transitions each held 40 cycles -> only the falling edge pulses; level[2] follows both.
REQ-034 pending[3]=1, clear[3]=1 on the same edge as a new qualifying edge -> pending[3] remains 1; clear next cycle alone -> pending[3]=0, irq=0.
REQ-035 rst pulsed at counter=10 of a rising debounce, input still high -> no pulse for that edge; fresh pulse at full latency after rst deasserts.
REQ-036 All 4 channels rising simultaneously, mode=01 -> pulse=4'b1111 for one cycle, pending=4'b1111.

Source files
------------

// File: rtl/edge_detect_multi.sv
// Multi-channel edge detector: synchroniser, per-channel debounce, mode-qualified pulse and sticky pending flags.
// Pulse is registered one cycle after a debounced edge is accepted; irq is the combinational OR of pending.
module edge_detect_multi #(
  parameter int CHANNELS        = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CHANNELS-1:0]   data_in,
  input  logic [2*CHANNELS-1:0] mode,
  input  logic [CHANNELS-1:0]   clear,
  output logic [CHANNELS-1:0]   level,
  output logic [CHANNELS-1:0]   pulse,
  output logic [CHANNELS-1:0]   pending,
  output logic                  irq
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
  logic [CW-1:0]       cnt    [CHANNELS];
  logic [CHANNELS-1:0] samp;
  logic [CHANNELS-1:0] accept;
  logic [CHANNELS-1:0] hit;

  assign samp = sync_q[SYNC_STAGES-1];

  // An edge is accepted only once the deviation has been seen DEBOUNCE_CYCLES times in a row;
  // the direction of the new level selects which mode bit qualifies it.
  always_comb begin
    accept = '0;
    hit    = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      accept[i] = (samp[i] != level[i]) && (cnt[i] == CNT_MAX);
      hit[i]    = accept[i] && (samp[i] ? mode[2*i] : mode[2*i+1]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      for (int i = 0; i < CHANNELS; i++) cnt[i] <= '0;
      level   <= '0;
      pulse   <= '0;
      pending <= '0;
    end else begin
      sync_q[0] <= data_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      for (int i = 0; i < CHANNELS; i++) begin
        if (samp[i] == level[i] || accept[i]) cnt[i] <= '0;
        else                                 cnt[i] <= cnt[i] + 1'b1;
      end
      level   <= level ^ accept;
      pulse   <= hit;
      // set wins over a coincident clear
      pending <= (pending & ~clear) | hit;
    end
  end

  assign irq = |pending;

endmodule

// File: tb/tb_edge_detect_multi.sv
// Directed bench for edge_detect_multi at default parameters; expected values are hand-derived latencies.
module tb_edge_detect_multi;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] data_in;
  logic [7:0] mode;
  logic [3:0] clear;
  logic [3:0] level;
  logic [3:0] pulse;
  logic [3:0] pending;
  logic       irq;

  int errors = 0;
  int checks = 0;
  int num;
  int first;

  always #5 clk = ~clk;

  edge_detect_multi dut (
    .clk     (clk),
    .rst     (rst),
    .data_in (data_in),
    .mode    (mode),
    .clear   (clear),
    .level   (level),
    .pulse   (pulse),
    .pending (pending),
    .irq     (irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Runs n cycles, counting pulses on one channel and noting the cycle of the first one.
  task automatic watch(input int n, input int ch, output int cnt_o, output int first_o);
    cnt_o   = 0;
    first_o = 0;
    for (int k = 1; k <= n; k++) begin
      tick(1);
      if (pulse[ch]) begin
        cnt_o++;
        if (first_o == 0) first_o = k;
      end
    end
  endtask

  initial begin
    rst     = 1'b1;
    data_in = 4'h0;
    mode    = 8'hFF;
    clear   = 4'hF;
    tick(3);
    check("rst_level",   level,   0);
    check("rst_pulse",   pulse,   0);
    check("rst_pending", pending, 0);
    check("rst_irq",     irq,     0);

    rst   = 1'b0;
    clear = 4'h0;
    mode  = 8'b01_10_11_01;   // ch3 rise, ch2 fall, ch1 both, ch0 rise
    tick(2);

    // ch0 rising: pulse on the 18th edge after the change
    data_in[0] = 1'b1;
    watch(17, 0, num, first);
    check("ch0_early_pulse", num, 0);
    check("ch0_early_level", level[0], 0);
    tick(1);
    check("ch0_pulse",   pulse,      4'b0001);
    check("ch0_level",   level[0],   1);
    check("ch0_pending", pending[0], 1);
    check("ch0_irq",     irq,        1);
    tick(1);
    check("ch0_pulse_one_cycle", pulse, 0);
    check("ch0_pending_sticky",  pending[0], 1);
    clear = 4'b0001;
    tick(1);
    clear = 4'h0;
    check("ch0_cleared",     pending, 0);
    check("ch0_irq_cleared", irq,     0);

    // ch1 glitch one cycle short of the debounce window
    data_in[1] = 1'b1;
    tick(15);
    data_in[1] = 1'b0;
    watch(40, 1, num, first);
    check("ch1_glitch_pulses",  num,        0);
    check("ch1_glitch_level",   level[1],   0);
    check("ch1_glitch_pending", pending[1], 0);

    // ch1 held exactly the window: both edges accepted in mode 11
    data_in[1] = 1'b1;
    tick(16);
    data_in[1] = 1'b0;
    watch(40, 1, num, first);
    check("ch1_min_pulses",  num,        2);
    check("ch1_min_first",   first,      2);
    check("ch1_min_level",   level[1],   0);
    check("ch1_min_pending", pending[1], 1);

    // ch2 falling-only
    data_in[2] = 1'b1;
    watch(40, 2, num, first);
    check("ch2_rise_pulses", num,      0);
    check("ch2_rise_level",  level[2], 1);
    data_in[2] = 1'b0;
    watch(40, 2, num, first);
    check("ch2_fall_pulses",  num,        1);
    check("ch2_fall_latency", first,      18);
    check("ch2_fall_level",   level[2],   0);
    check("ch2_fall_pending", pending[2], 1);

    // ch3 set/clear collision
    clear = 4'b0111;
    tick(1);
    clear = 4'h0;
    data_in[3] = 1'b1;
    watch(20, 3, num, first);
    check("ch3_first_pulses", num,        1);
    check("ch3_first_pend",   pending[3], 1);
    data_in[3] = 1'b0;
    watch(20, 3, num, first);
    check("ch3_fall_pulses", num, 0);
    data_in[3] = 1'b1;
    tick(17);
    clear = 4'b1000;
    tick(1);
    check("ch3_collide_pulse",   pulse[3],   1);
    check("ch3_collide_pending", pending[3], 1);
    tick(1);
    clear = 4'h0;
    check("ch3_clear_pending", pending[3], 0);
    check("ch3_clear_irq",     irq,        0);

    // reset mid-debounce on ch0
    data_in[0] = 1'b0;
    watch(20, 0, num, first);
    check("ch0_fall_pulses", num,      0);
    check("ch0_fall_level",  level[0], 0);
    data_in[0] = 1'b1;
    tick(12);
    rst   = 1'b1;
    mode  = 8'h00;
    clear = 4'hF;
    tick(1);
    check("midrst_level",   level,   0);
    check("midrst_pulse",   pulse,   0);
    check("midrst_pending", pending, 0);
    check("midrst_irq",     irq,     0);
    mode  = 8'b01_10_11_01;
    clear = 4'h0;
    rst   = 1'b0;
    watch(17, 0, num, first);
    check("postrst_early_pulses", num, 0);
    tick(1);
    check("postrst_pulse", pulse[0], 1);
    check("postrst_level", level[0], 1);

    // all channels rising together
    data_in = 4'h0;
    tick(20);
    clear = 4'hF;
    tick(1);
    clear   = 4'h0;
    mode    = 8'b01_01_01_01;
    data_in = 4'hF;
    tick(17);
    check("all_early_pulse", pulse, 0);
    tick(1);
    check("all_pulse",   pulse,   4'hF);
    check("all_pending", pending, 4'hF);
    check("all_level",   level,   4'hF);
    tick(1);
    check("all_pulse_one_cycle", pulse, 0);

    // mode 00 keeps tracking level without events
    mode  = 8'b01_01_01_00;
    clear = 4'hF;
    tick(1);
    clear      = 4'h0;
    data_in[0] = 1'b0;
    watch(20, 0, num, first);
    check("off_pulses",  num,        0);
    check("off_level",   level[0],   0);
    data_in[0] = 1'b1;
    watch(20, 0, num, first);
    check("off_rise_pulses",  num,        0);
    check("off_rise_level",   level[0],   1);
    check("off_rise_pending", pending[0], 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
